// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared constants, element/accumulator types and the sequencer
//               state encoding for the mat_vec_mult sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DIM        = 8;
  localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef logic [ACC_WIDTH-1:0]  acc_t;
  typedef elem_t [DIM-1:0]       elem_vec_t;
  typedef acc_t  [DIM-1:0]       acc_vec_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLR    = 4'd1,
    RD_A   = 4'd2,
    WT_A   = 4'd3,
    RD_B   = 4'd4,
    WT_B   = 4'd5,
    PUSH_B = 4'd6,
    RUN    = 4'd7,
    CAPT   = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mvm_seq_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : mvm_seq_rd_port
// Description : Memory read port for the sequencer. Turns a launch request
//               into a registered one-cycle mem_rd/mem_addr, enforces a
//               single outstanding read, qualifies mem_rvalid against that
//               outstanding read and registers the returned word.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               launch/launch_addr - request a read (strobe appears next cycle)
//               abort              - forget the outstanding read
//               mem_rd/mem_addr    - read request to memory
//               mem_rvalid/rdata   - read response from memory
//               rsp_valid          - accepted response this cycle
//               word               - last accepted read word
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_seq_rd_port #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch,
  input  logic [ADDR_W-1:0] launch_addr,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] word
);
  import mvm_pkg::*;

  logic outstanding;
  logic issue;

  // A response is only meaningful while our single read is in flight; data
  // cannot legally return in the same cycle as the request itself.
  assign rsp_valid = mem_rvalid & outstanding & ~mem_rd;

  // The slot frees up in the cycle the response is accepted, so a new
  // request may be launched back-to-back with the accepted response.
  assign issue = launch & (~outstanding | rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      outstanding <= 1'b0;
      word        <= '0;
    end else begin
      mem_rd <= issue;
      if (issue) begin
        mem_addr <= launch_addr;
      end
      if (issue) begin
        outstanding <= 1'b1;
      end else if (rsp_valid || abort) begin
        outstanding <= 1'b0;
      end
      if (rsp_valid) begin
        word <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvm_seq_ctrl
// Description : Sequencer for the 8-lane mat_vec_mult datapath. On start it
//               clears the MAC array, fetches eight matrix columns and one
//               vector word, streams them into the A FIFOs and B FIFO, waits
//               for the datapath done and latches the accumulators.
// Option      : `define MVM_SEQ_TIMEOUT_EN adds output err and a watchdog of
//               TIMEOUT_CYCLES cycles on WT_A, WT_B and RUN.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               start, base_addr         - job request and matrix base address
//               busy, done, result       - job status and latched results
//               mem_rd/addr/rdata/rvalid - word-wide memory read port
//               mv_clr, mv_a_*, mv_b_*   - datapath clear and FIFO pushes
//               mv_done, mv_out          - datapath completion/accumulators
//               err (option only)        - job ended by watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int DIM            = 8,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic [DIM-1:0][3*DATA_WIDTH-1:0]     result,
  output logic                                 mem_rd,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic [DIM*DATA_WIDTH-1:0]            mem_rdata,
  input  logic                                 mem_rvalid,
  output logic                                 mv_clr,
  output logic                                 mv_a_wren,
  output logic [DIM-1:0][DATA_WIDTH-1:0]       mv_a_data,
  output logic                                 mv_b_wren,
  output logic [DATA_WIDTH-1:0]                mv_b_data,
  input  logic                                 mv_done,
  input  logic [DIM-1:0][3*DATA_WIDTH-1:0]     mv_out
`ifdef MVM_SEQ_TIMEOUT_EN
  ,
  output logic                                 err
`endif
);
  import mvm_pkg::*;

  localparam int WORD_W = DIM * DATA_WIDTH;
  localparam int IDX_W  = $clog2(DIM);
  localparam int CNT_W  = IDX_W + 1;

  state_t                          state;
  logic [ADDR_W-1:0]               base;
  logic [CNT_W-1:0]                k;      // matrix columns pushed so far
  logic [CNT_W-1:0]                j;      // vector elements pushed so far
  logic [DIM-1:0][DATA_WIDTH-1:0]  b_vec;

  logic                            launch;
  logic [ADDR_W-1:0]               launch_addr;
  logic                            rsp_valid;
  logic [WORD_W-1:0]               word;
  logic                            timeout;

  // Reads are launched on the edge that enters RD_A/RD_B so the registered
  // mem_rd is high exactly during those states. Column k+1 (or the vector
  // word at base+8 after the last column) is requested while column k is
  // being pushed.
  assign launch      = (state == CLR) || ((state == WT_A) && rsp_valid);
  assign launch_addr = base + ADDR_W'((state == CLR) ? '0 : (k + 1'b1));

  // The read port's word register is loaded on the accepting edge, which
  // is exactly when mv_a_wren goes high, so it doubles as the A data stage.
  assign mv_a_data = word;

  mvm_seq_rd_port #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_rd_port (
    .clk         (clk),
    .rst         (rst),
    .launch      (launch),
    .launch_addr (launch_addr),
    .abort       (timeout),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rsp_valid   (rsp_valid),
    .word        (word)
  );

`ifdef MVM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_hold;

  // The counter only advances while parked in a waiting state; any state
  // change (including leaving via the watchdog itself) restarts it at zero.
  assign to_hold = (((state == WT_A) || (state == WT_B)) && !rsp_valid) ||
                   ((state == RUN) && !mv_done);
  assign timeout = to_hold && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !to_hold || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      k         <= '0;
      j         <= '0;
      b_vec     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      mv_clr    <= 1'b0;
      mv_a_wren <= 1'b0;
      mv_b_wren <= 1'b0;
      mv_b_data <= '0;
    end else begin
      mv_clr    <= 1'b0;
      mv_a_wren <= 1'b0;
      mv_b_wren <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base   <= base_addr;
            busy   <= 1'b1;
            mv_clr <= 1'b1;
            state  <= CLR;
          end
        end
        CLR: begin
          k     <= '0;
          state <= RD_A;
        end
        RD_A: begin
          state <= WT_A;
        end
        WT_A: begin
          if (rsp_valid) begin
            mv_a_wren <= 1'b1;
            k         <= k + 1'b1;
            state     <= (k == CNT_W'(DIM - 1)) ? RD_B : RD_A;
          end else if (timeout) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= CAPT;
          end
        end
        RD_B: begin
          state <= WT_B;
        end
        WT_B: begin
          if (rsp_valid) begin
            // Element 0 goes out immediately; the rest follow from b_vec.
            b_vec     <= mem_rdata;
            mv_b_wren <= 1'b1;
            mv_b_data <= mem_rdata[DATA_WIDTH-1:0];
            j         <= CNT_W'(1);
            state     <= PUSH_B;
          end else if (timeout) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= CAPT;
          end
        end
        PUSH_B: begin
          if (j == CNT_W'(DIM)) begin
            state <= RUN;
          end else begin
            mv_b_wren <= 1'b1;
            mv_b_data <= b_vec[j[IDX_W-1:0]];
            j         <= j + 1'b1;
          end
        end
        RUN: begin
          if (mv_done) begin
            result <= mv_out;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= CAPT;
          end else if (timeout) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= CAPT;
          end
        end
        CAPT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
